// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-requester memory arbiter: FSM encoding,
// owner encoding and the NOP instruction word also used by I_cache.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic other_side(input logic side);
    return (side == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// side that did not complete the previous transaction.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant_owner = OWN_I;
    if (req_i && req_d) begin
      grant_owner = other_side(last_owner);
    end else if (req_d) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-side refills and D-side loads/stores onto one req/ack memory
// port; each transaction ends with a one-cycle ready pulse to its owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              owner,
  output logic              busy
);

  logic [1:0]        r_state;
  logic              r_last_owner;
  logic              r_owner;
  logic              r_busy;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_i_data;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;

  logic w_grant_valid;
  logic w_grant_owner;

  rr_pick2 u_pick (
    .req_i       (i_req),
    .req_d       (d_req),
    .last_owner  (r_last_owner),
    .grant_valid (w_grant_valid),
    .grant_owner (w_grant_owner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_owner <= OWN_D;
      r_owner      <= OWN_D;
      r_busy       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_i_data     <= '0;
      r_d_rdata    <= '0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_owner   <= w_grant_owner;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_BUSY;
            if (w_grant_owner == OWN_D) begin
              r_mem_addr  <= d_addr;
              r_mem_we    <= d_we;
              r_mem_wdata <= d_wdata;
            end else begin
              r_mem_addr  <= i_addr;
              r_mem_we    <= 1'b0;
              r_mem_wdata <= '0;
            end
          end
        end
        ST_BUSY: begin
          // Request payload stays latched; only the ack moves us on.
          if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_last_owner <= r_owner;
            r_state      <= ST_DONE;
            if (r_owner == OWN_I) begin
              r_i_data  <= mem_rdata;
              r_i_ready <= 1'b1;
            end else begin
              r_d_ready <= 1'b1;
              if (!r_mem_we) begin
                r_d_rdata <= mem_rdata;
              end
            end
          end
        end
        ST_DONE: begin
          r_i_ready <= 1'b0;
          r_d_ready <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_i_ready <= 1'b0;
          r_d_ready <= 1'b0;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign i_data    = r_i_data;
  assign i_ready   = r_i_ready;
  assign d_rdata   = r_d_rdata;
  assign d_ready   = r_d_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign owner     = r_owner;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Transaction-level bench for mem_arbiter: directed scenarios followed by
// random mixed traffic, checked against a round-robin reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        owner;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: who finished last and what each side last read.
  bit          m_last;
  logic [31:0] m_idata;
  logic [31:0] m_drdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_ready   (i_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last   = 1'b1;
    m_idata  = '0;
    m_drdata = '0;
  endtask

  // One full transaction from grant to return-to-IDLE. Requests/payload are
  // set by the caller before entry; the winner is predicted from them.
  task automatic run_txn(input int lat, input bit keep, input bit perturb,
                         input logic [31:0] rd);
    bit          w;
    bit          ewe;
    logic [31:0] ea;
    logic [31:0] ew;
    w   = (i_req && d_req) ? ~m_last : d_req;
    ea  = w ? d_addr : i_addr;
    ewe = w ? d_we : 1'b0;
    ew  = d_wdata;
    step();
    chk("grant_req",   {31'b0, mem_req}, 32'd1);
    chk("grant_busy",  {31'b0, busy},    32'd1);
    chk("grant_owner", {31'b0, owner},   {31'b0, w});
    chk("grant_addr",  mem_addr,         ea);
    chk("grant_we",    {31'b0, mem_we},  {31'b0, ewe});
    if (w) chk("grant_wdata", mem_wdata, ew);
    for (int k = 0; k < lat; k++) begin
      if (perturb) begin
        if (w) begin
          d_addr  = d_addr ^ 32'h0000_0C00;
          d_we    = ~d_we;
          d_wdata = $urandom;
          if ($urandom_range(0, 2) == 0) d_req = 1'b0;
        end else begin
          i_addr = i_addr ^ 32'h0000_0C00;
          if ($urandom_range(0, 2) == 0) i_req = 1'b0;
        end
      end
      step();
      chk("hold_req",  {31'b0, mem_req}, 32'd1);
      chk("hold_addr", mem_addr,         ea);
      chk("hold_we",   {31'b0, mem_we},  {31'b0, ewe});
      if (w) chk("hold_wdata", mem_wdata, ew);
      chk("hold_rdy",  {30'b0, i_ready, d_ready}, 32'd0);
    end
    mem_rdata = rd;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (!w) m_idata = rd;
    else if (!ewe) m_drdata = rd;
    m_last = w;
    chk("done_req",  {31'b0, mem_req}, 32'd0);
    chk("done_busy", {31'b0, busy},    32'd1);
    chk("done_rdy",  {30'b0, i_ready, d_ready}, w ? 32'd1 : 32'd2);
    if (!w) chk("done_idata", i_data, m_idata);
    else    chk("done_drdata", d_rdata, m_drdata);
    if (!keep) begin
      if (w) d_req = 1'b0;
      else   i_req = 1'b0;
    end
    step();
    chk("idle_rdy",  {30'b0, i_ready, d_ready}, 32'd0);
    chk("idle_busy", {31'b0, busy},    32'd0);
    chk("idle_req",  {31'b0, mem_req}, 32'd0);
    $display("txn owner=%0d addr=%h we=%0d rdata=%h lat=%0d", w, ea, ewe, rd, lat);
  endtask

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; mem_rdata = 0; mem_ack = 0;
    model_reset();
    step();
    step();
    chk("rst_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_busy",  {31'b0, busy},    32'd0);
    chk("rst_rdy",   {30'b0, i_ready, d_ready}, 32'd0);
    chk("rst_addr",  mem_addr,  32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_idata", i_data,    32'd0);
    chk("rst_drdata", d_rdata,  32'd0);
    rst = 1'b0;
    step();

    // Simultaneous requests right after reset: strict I,D,I,D.
    i_req = 1; i_addr = 32'h0000_1000; d_req = 1; d_we = 0; d_addr = 32'h0000_3000;
    for (int n = 0; n < 4; n++) run_txn(0, 1'b1, 1'b0, $urandom);
    i_req = 0; d_req = 0;
    step();

    // I-only read, ack two cycles after mem_req.
    i_req = 1; i_addr = 32'h0000_0400;
    run_txn(1, 1'b0, 1'b0, 32'h0010_0093);

    // D store: d_rdata must stay at its last load value.
    d_req = 1; d_we = 1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
    run_txn(2, 1'b0, 1'b0, 32'h5555_AAAA);

    // Requester inputs wander while BUSY; latched values must hold.
    i_req = 1; i_addr = 32'h0000_0400;
    run_txn(5, 1'b0, 1'b1, $urandom);
    i_req = 0;

    // Reset one cycle before the ack: transaction abandoned, late ack ignored.
    d_req = 1; d_we = 0; d_addr = 32'h0000_4000;
    step();
    chk("r5_req", {31'b0, mem_req}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; d_req = 0;
    model_reset();
    chk("r5_req0",  {31'b0, mem_req}, 32'd0);
    chk("r5_busy0", {31'b0, busy},    32'd0);
    chk("r5_rdy0",  {30'b0, i_ready, d_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_ack = 1'b0;
    chk("late_ack_rdy",  {30'b0, i_ready, d_ready}, 32'd0);
    chk("late_ack_busy", {31'b0, busy}, 32'd0);
    chk("late_ack_data", d_rdata, 32'd0);
    i_req = 1; i_addr = 32'h0000_0500; d_req = 1; d_we = 0; d_addr = 32'h0000_6000;
    run_txn(0, 1'b0, 1'b0, $urandom);
    d_req = 0;
    step();

    // Spurious ack in IDLE.
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("spur_req",  {31'b0, mem_req}, 32'd0);
    chk("spur_busy", {31'b0, busy},    32'd0);
    chk("spur_rdy",  {30'b0, i_ready, d_ready}, 32'd0);

    // Random mixed traffic; an unserved side keeps its request pending.
    for (int n = 0; n < 30; n++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      if (!i_req && !d_req) begin
        i_req = 1; i_addr = $urandom;
      end
      run_txn($urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single main-memory port between two requesters:
  - the I_cache refill path (read-only);
  - the data-side load/store path.
- Serialises one transaction at a time over a req/ack memory handshake and returns read data with a one-cycle ready pulse.
- The pulse drives I_cache's mem_ready/mem_Data directly.
- Round-robin on simultaneous requests, so neither side starves.

Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-side read request, held until i_ready
- i_addr  in  ADDR_W  I-side word address
- i_data  out  DATA_W  I-side read data, valid while i_ready=1
- i_ready  out  1  one-cycle completion pulse to I_cache (mem_ready)
- d_req  in  1  D-side request, held until d_ready
- d_we  in  1  D-side write enable (1=store, 0=load)
- d_addr  in  ADDR_W  D-side address
- d_wdata  in  DATA_W  D-side store data
- d_rdata  out  DATA_W  D-side load data, valid while d_ready=1
- d_ready  out  1  one-cycle D-side completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, sampled with mem_ack
- mem_ack  in  1  memory completion, one cycle
- owner  out  1  current/last grant holder: 0=I, 1=D
- busy  out  1  1 in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE;
  - mem_req, mem_we, i_ready, d_ready, busy = 0;
  - mem_addr, mem_wdata, i_data, d_rdata = 0;
  - last_owner=D, so the first tie goes to I.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If exactly one of i_req/d_req is high, grant it.
  - If both are high, grant the side != last_owner.
  - On grant, latch the granted addr/we/wdata into mem_* (I side forces mem_we=0), set owner, set mem_req=1, go to BUSY.
  - If neither request is high, stay in IDLE.
- BUSY:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - On mem_ack=1:
    - mem_req<=0;
    - capture mem_rdata into i_data (owner I) or d_rdata (owner D, load only; stores leave d_rdata unchanged);
    - pulse the owner's ready for one cycle;
    - last_owner<=owner;
    - go to DONE.
- DONE:
  - Lasts exactly one cycle, with ready=1 during it.
  - No grant is made; the requester drops req on the edge that ends DONE.
  - Next state is IDLE, with ready=0.
- Latency: req seen at edge T gives mem_req=1 from T+1. mem_ack at edge A gives ready=1 for cycle A+1 and IDLE at A+2. Minimum issue-to-issue spacing is 3 cycles plus memory latency.
- Fairness: under continuous requests from both sides, grants strictly alternate I,D,I,D.
- Boundary cases:
  - Request dropped during BUSY: ignored; the transaction completes and ready still pulses.
  - Requester input changes during BUSY: no effect; values were latched at grant.
  - mem_ack in IDLE or DONE: ignored.
  - rst in any state: next cycle is IDLE, mem_req=0, ready=0. The in-flight transaction is abandoned and no ready pulse is issued.
  - i_ready and d_ready are never high in the same cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants ST_IDLE/ST_BUSY/ST_DONE;
  - owner encoding OWN_I=0, OWN_D=1;
  - NOP constant 32'h00000013, shared with I_cache.
- Sub-module rr_pick2 (combinational): inputs req_i, req_d, last_owner; outputs grant_valid and grant_owner. Instantiated once.

Test Plan:
1. I-only read: i_req=1, i_addr=0x0000_0400; memory acks 2 cycles after mem_req with mem_rdata=0x0010_0093 -> mem_addr=0x400, mem_we=0, one-cycle i_ready with i_data=0x0010_0093, d_ready stays 0.
2. D store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF held until ack, d_ready pulses, d_rdata unchanged.
3. Simultaneous after reset: i_req=d_req=1 held for 4 transactions, 1-cycle ack -> grant order I,D,I,D, owner toggles, exactly 4 ready pulses.
4. Address change mid-BUSY: i_addr changes 0x400 -> 0x800 while waiting 5 cycles for ack -> mem_addr stays 0x400 throughout.
5. Reset mid-BUSY: rst=1 one cycle before ack -> mem_req=0, busy=0 next cycle, no ready pulse; the late ack is ignored; the next tie goes to I.
6. Spurious ack: mem_ack=1 in IDLE with no requests -> no state change, no ready, mem_req stays 0.
